id_ex_operand_stage: RTL and testbench
======================================

// Module: id_ex_operand_stage
// PURPOSE
// ID/EX pipeline register plus EX-stage operand selection. It feeds the ALU directly with alu_op_out, alu_in_1 and alu_in_2.
// Captures decoded instructions, inserts bubbles on load-use hazards and on flush, and holds on external stall.
// Forwards EX/MEM and MEM/WB results into the ALU operands and the store data.
// PARAMETERS
// XLEN        32  datapath width
// REG_ADDR_W  5   register index width
// PORTS
// clk              in   1     rising-edge clock
// reset            in   1     synchronous, active-low (0 = reset)
// id_valid         in   1     ID holds a real instruction
// id_pc            in   XLEN  PC of ID instruction
// id_rs1_data      in   XLEN  register-file read data, rs1
// id_rs2_data      in   XLEN  register-file read data, rs2
// id_imm           in   XLEN  sign-extended immediate
// id_rs1, id_rs2   in   5     source indices
// id_rs1_used      in   1     instruction reads rs1
// id_rs2_used      in   1     instruction reads rs2
// id_rd            in   5     destination index
// id_alu_op        in   4     ALU op code (`ALU_* from opcodes.v)
// id_src1_pc       in   1     1: alu_in_1=pc, 0: rs1
// id_src2_imm      in   1     1: alu_in_2=imm, 0: rs2
// id_reg_write, id_mem_read, id_mem_write, id_is_branch  in 1  control bits
// stall_in         in   1     downstream/memory stall: hold EX register
// flush            in   1     branch mispredict: kill EX contents
// exm_reg_write    in   1     EX/MEM writes a register
// exm_rd           in   5     EX/MEM destination
// exm_result       in   XLEN  EX/MEM ALU result
// mwb_reg_write    in   1     MEM/WB writes a register
// mwb_rd           in   5     MEM/WB destination
// mwb_wdata        in   XLEN  MEM/WB write-back data
// load_use_stall   out  1     combinational: freeze PC and IF/ID
// ex_valid         out  1     EX holds a real instruction
// alu_op_out       out  4     to ALU
// alu_in_1         out  XLEN  to ALU
// alu_in_2         out  XLEN  to ALU
// ex_store_data    out  XLEN  forwarded rs2 for stores
// ex_branch_target out  XLEN  ex_pc + ex_imm (mod 2^XLEN)
// ex_pc, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write, ex_is_branch  out  registered copies
// BEHAVIOUR
// - Reset (reset==0 at posedge): all EX registers are 0, so ex_valid=0, all control bits=0, alu_op_out=0.
//   alu_in_1 and alu_in_2 are then 0 unless forwarding is active. load_use_stall=0.
// - load_use_stall = ex_valid & ex_mem_read & ex_rd!=0 & ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd)).
// - Update priority at posedge:
//   1. flush: bubble, i.e. valid and all control bits = 0, data regs 0.
//   2. stall_in: hold. Data regs rs1/rs2 reload with their current forwarded values, so a producer leaving MEM/WB is not lost.
//   3. load_use_stall: bubble.
//   4. Otherwise, capture ID, 1-cycle latency. If id_valid=0, the captured control bits are forced to 0.
// - Forwarding, combinational, per operand:
//   - EX/MEM if exm_reg_write & exm_rd!=0 & exm_rd==ex_rsX.
//   - Else MEM/WB if mwb_reg_write & mwb_rd!=0 & mwb_rd==ex_rsX.
//   - Else the registered value.
//   - EX/MEM wins when both match.
//   - Register x0 is never forwarded and always reads the registered value.
// - alu_in_1 = src1_pc ? ex_pc : fwd_rs1; alu_in_2 = src2_imm ? ex_imm : fwd_rs2; ex_store_data = fwd_rs2.
// - ex_branch_target wraps mod 2^XLEN; there is no overflow flag.
// - flush and stall_in in the same cycle: flush wins.
// - Reset asserted mid-stall: reset wins over everything.
// TESTING
// - Reset: hold reset=0 for 2 cycles -> ex_valid=0, alu_op_out=0, ex_reg_write=0, load_use_stall=0.
// - Pass-through: id add, rs1_data=5, rs2_data=7, no hazards -> next cycle alu_in_1=5, alu_in_2=7, alu_op_out=`ALU_ADD, ex_valid=1.
// - Forward priority: ex_rs1=3; exm_rd=3, exm_result=0x11; mwb_rd=3, mwb_wdata=0x22 -> alu_in_1=0x11.
//   Drop exm_reg_write -> alu_in_1=0x22.
//   Set rd=0 on both -> registered value.
// - Load-use: EX holds lw x4; ID has add using rs2=x4 -> load_use_stall=1, next cycle ex_valid=0.
//   Following cycle the add enters EX with ex_valid=1.
// - Stall capture: stall_in=1 for 3 cycles while MEM/WB forwards 0xAB to rs1, then MEM/WB retires -> alu_in_1 stays 0xAB.
// - Flush with stall: flush=1 and stall_in=1 together -> ex_valid=0, ex_mem_write=0.
//   Branch target check: ex_pc=0xFFFFFFFC, imm=8 -> ex_branch_target=0x00000004.

Source files
------------

// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage
// ID/EX pipeline register with EX-stage operand selection and forwarding.
//
// Ports:
//   clk, reset (synchronous, active-low)
//   id_*            decoded instruction from ID (data, indices, control)
//   stall_in        hold the EX register (operands keep tracking forwards)
//   flush           replace EX contents with a bubble
//   exm_* / mwb_*   EX/MEM and MEM/WB write-back sources for forwarding
//   load_use_stall  combinational: freeze PC and IF/ID
//   ex_valid, alu_op_out, alu_in_1, alu_in_2, ex_store_data,
//   ex_branch_target, ex_pc, ex_rd, ex_reg_write, ex_mem_read,
//   ex_mem_write, ex_is_branch   EX-stage outputs
module id_ex_operand_stage #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [XLEN-1:0]       id_pc,
    input  logic [XLEN-1:0]       id_rs1_data,
    input  logic [XLEN-1:0]       id_rs2_data,
    input  logic [XLEN-1:0]       id_imm,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic [3:0]            id_alu_op,
    input  logic                  id_src1_pc,
    input  logic                  id_src2_imm,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  id_mem_write,
    input  logic                  id_is_branch,
    input  logic                  stall_in,
    input  logic                  flush,
    input  logic                  exm_reg_write,
    input  logic [REG_ADDR_W-1:0] exm_rd,
    input  logic [XLEN-1:0]       exm_result,
    input  logic                  mwb_reg_write,
    input  logic [REG_ADDR_W-1:0] mwb_rd,
    input  logic [XLEN-1:0]       mwb_wdata,
    output logic                  load_use_stall,
    output logic                  ex_valid,
    output logic [3:0]            alu_op_out,
    output logic [XLEN-1:0]       alu_in_1,
    output logic [XLEN-1:0]       alu_in_2,
    output logic [XLEN-1:0]       ex_store_data,
    output logic [XLEN-1:0]       ex_branch_target,
    output logic [XLEN-1:0]       ex_pc,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  ex_reg_write,
    output logic                  ex_mem_read,
    output logic                  ex_mem_write,
    output logic                  ex_is_branch
);

    typedef struct packed {
        logic                  valid;
        logic [XLEN-1:0]       pc;
        logic [XLEN-1:0]       rs1_data;
        logic [XLEN-1:0]       rs2_data;
        logic [XLEN-1:0]       imm;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic [REG_ADDR_W-1:0] rd;
        logic [3:0]            alu_op;
        logic                  src1_pc;
        logic                  src2_imm;
        logic                  reg_write;
        logic                  mem_read;
        logic                  mem_write;
        logic                  is_branch;
    } ex_regs_t;

    ex_regs_t ex_q;
    ex_regs_t ex_d;

    // Operand 0 is rs1, operand 1 is rs2.
    logic [1:0][REG_ADDR_W-1:0] src_idx;
    logic [1:0][XLEN-1:0]       src_val;
    logic [1:0][XLEN-1:0]       fwd_val;

    assign src_idx[0] = ex_q.rs1;
    assign src_idx[1] = ex_q.rs2;
    assign src_val[0] = ex_q.rs1_data;
    assign src_val[1] = ex_q.rs2_data;

    // EX/MEM is the younger producer, so it is checked first; x0 never forwards.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            assign fwd_val[gi] =
                (exm_reg_write && (exm_rd != '0) && (exm_rd == src_idx[gi])) ? exm_result :
                (mwb_reg_write && (mwb_rd != '0) && (mwb_rd == src_idx[gi])) ? mwb_wdata  :
                                                                               src_val[gi];
        end
    endgenerate

    assign load_use_stall = ex_q.valid && ex_q.mem_read && (ex_q.rd != '0) &&
                            ((id_rs1_used && (id_rs1 == ex_q.rd)) ||
                             (id_rs2_used && (id_rs2 == ex_q.rd)));

    always_comb begin
        ex_d = ex_q;
        if (flush) begin
            ex_d = '0;
        end else if (stall_in) begin
            // Refresh held operands so a producer retiring from MEM/WB during
            // the stall is captured before it disappears.
            ex_d.rs1_data = fwd_val[0];
            ex_d.rs2_data = fwd_val[1];
        end else if (load_use_stall) begin
            ex_d = '0;
        end else begin
            ex_d.valid     = id_valid;
            ex_d.pc        = id_pc;
            ex_d.rs1_data  = id_rs1_data;
            ex_d.rs2_data  = id_rs2_data;
            ex_d.imm       = id_imm;
            ex_d.rs1       = id_rs1;
            ex_d.rs2       = id_rs2;
            ex_d.rd        = id_rd;
            ex_d.alu_op    = id_alu_op;
            ex_d.src1_pc   = id_src1_pc;
            ex_d.src2_imm  = id_src2_imm;
            ex_d.reg_write = id_valid & id_reg_write;
            ex_d.mem_read  = id_valid & id_mem_read;
            ex_d.mem_write = id_valid & id_mem_write;
            ex_d.is_branch = id_valid & id_is_branch;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    assign ex_valid         = ex_q.valid;
    assign alu_op_out       = ex_q.alu_op;
    assign alu_in_1         = ex_q.src1_pc  ? ex_q.pc  : fwd_val[0];
    assign alu_in_2         = ex_q.src2_imm ? ex_q.imm : fwd_val[1];
    assign ex_store_data    = fwd_val[1];
    assign ex_branch_target = ex_q.pc + ex_q.imm;
    assign ex_pc            = ex_q.pc;
    assign ex_rd            = ex_q.rd;
    assign ex_reg_write     = ex_q.reg_write;
    assign ex_mem_read      = ex_q.mem_read;
    assign ex_mem_write     = ex_q.mem_write;
    assign ex_is_branch     = ex_q.is_branch;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Testbench for id_ex_operand_stage: directed scenarios followed by random
// traffic, all checked against a behavioural model of the EX stage.
module tb_id_ex_operand_stage;

    localparam logic [3:0] ALU_ADD = 4'h0;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_rs1_used, id_rs2_used;
    logic [3:0]  id_alu_op;
    logic        id_src1_pc, id_src2_imm;
    logic        id_reg_write, id_mem_read, id_mem_write, id_is_branch;
    logic        stall_in, flush;
    logic        exm_reg_write, mwb_reg_write;
    logic [4:0]  exm_rd, mwb_rd;
    logic [31:0] exm_result, mwb_wdata;
    logic        load_use_stall, ex_valid;
    logic [3:0]  alu_op_out;
    logic [31:0] alu_in_1, alu_in_2, ex_store_data, ex_branch_target, ex_pc;
    logic [4:0]  ex_rd;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_is_branch;

    always #5 clk = ~clk;

    id_ex_operand_stage dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used),
        .id_rs2_used(id_rs2_used), .id_rd(id_rd), .id_alu_op(id_alu_op),
        .id_src1_pc(id_src1_pc), .id_src2_imm(id_src2_imm),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_is_branch(id_is_branch),
        .stall_in(stall_in), .flush(flush),
        .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
        .mwb_reg_write(mwb_reg_write), .mwb_rd(mwb_rd), .mwb_wdata(mwb_wdata),
        .load_use_stall(load_use_stall), .ex_valid(ex_valid),
        .alu_op_out(alu_op_out), .alu_in_1(alu_in_1), .alu_in_2(alu_in_2),
        .ex_store_data(ex_store_data), .ex_branch_target(ex_branch_target),
        .ex_pc(ex_pc), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_is_branch(ex_is_branch)
    );

    // Model of what the EX stage currently holds.
    typedef struct packed {
        logic        v;
        logic [31:0] pc, a, b, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [3:0]  op;
        logic        s1pc, s2imm, rw, mr, mw, br;
    } ex_t;

    ex_t m;
    int  n_cmp = 0;
    int  n_err = 0;
    int  n_txn = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Value an operand reads after forwarding from the two write-back sources.
    function automatic logic [31:0] operand(input logic [4:0] idx, input logic [31:0] held);
        if (idx != 0 && exm_reg_write && exm_rd == idx) return exm_result;
        if (idx != 0 && mwb_reg_write && mwb_rd == idx) return mwb_wdata;
        return held;
    endfunction

    function automatic logic hazard();
        return m.v && m.mr && m.rd != 0 &&
               ((id_rs1_used && id_rs1 == m.rd) || (id_rs2_used && id_rs2 == m.rd));
    endfunction

    function automatic ex_t next_state();
        ex_t n;
        n = m;
        if (!reset || flush) begin
            n = '0;
        end else if (stall_in) begin
            n.a = operand(m.rs1, m.a);
            n.b = operand(m.rs2, m.b);
        end else if (hazard()) begin
            n = '0;
        end else begin
            n.v = id_valid;       n.pc = id_pc;        n.a = id_rs1_data;
            n.b = id_rs2_data;    n.imm = id_imm;      n.rs1 = id_rs1;
            n.rs2 = id_rs2;       n.rd = id_rd;        n.op = id_alu_op;
            n.s1pc = id_src1_pc;  n.s2imm = id_src2_imm;
            n.rw = id_valid && id_reg_write;  n.mr = id_valid && id_mem_read;
            n.mw = id_valid && id_mem_write;  n.br = id_valid && id_is_branch;
        end
        return n;
    endfunction

    // Called just after a negedge with inputs set: checks all outputs, then
    // advances the model across the next posedge and returns at the negedge.
    task automatic step();
        ex_t n;
        #1;
        check_eq("load_use_stall", {31'd0, load_use_stall}, {31'd0, hazard()});
        check_eq("ex_valid",       {31'd0, ex_valid},       {31'd0, m.v});
        check_eq("alu_op_out",     {28'd0, alu_op_out},     {28'd0, m.op});
        check_eq("alu_in_1",       alu_in_1,  m.s1pc  ? m.pc  : operand(m.rs1, m.a));
        check_eq("alu_in_2",       alu_in_2,  m.s2imm ? m.imm : operand(m.rs2, m.b));
        check_eq("ex_store_data",  ex_store_data, operand(m.rs2, m.b));
        check_eq("ex_branch_target", ex_branch_target, m.pc + m.imm);
        check_eq("ex_pc",          ex_pc, m.pc);
        check_eq("ex_rd",          {27'd0, ex_rd}, {27'd0, m.rd});
        check_eq("ex_ctrl", {28'd0, ex_reg_write, ex_mem_read, ex_mem_write, ex_is_branch},
                            {28'd0, m.rw, m.mr, m.mw, m.br});
        n = next_state();
        $display("txn %0d: rst=%0b fl=%0b st=%0b lu=%0b idv=%0b ex_v=%0b a1=%08h a2=%08h",
                 n_txn, reset, flush, stall_in, load_use_stall, id_valid, ex_valid,
                 alu_in_1, alu_in_2);
        n_txn++;
        @(posedge clk);
        m = n;
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        reset = 1'b1; id_valid = 1'b0; id_pc = '0; id_rs1_data = '0; id_rs2_data = '0;
        id_imm = '0; id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_rs1_used = 1'b0;
        id_rs2_used = 1'b0; id_alu_op = '0; id_src1_pc = 1'b0; id_src2_imm = 1'b0;
        id_reg_write = 1'b0; id_mem_read = 1'b0; id_mem_write = 1'b0; id_is_branch = 1'b0;
        stall_in = 1'b0; flush = 1'b0; exm_reg_write = 1'b0; exm_rd = '0; exm_result = '0;
        mwb_reg_write = 1'b0; mwb_rd = '0; mwb_wdata = '0;
    endtask

    task automatic random_inputs();
        reset        = ($urandom_range(0, 39) != 0);
        id_valid     = ($urandom_range(0, 5) != 0);
        id_pc        = $urandom;
        id_rs1_data  = $urandom;
        id_rs2_data  = $urandom;
        id_imm       = $urandom;
        id_rs1       = 5'($urandom_range(0, 3));
        id_rs2       = 5'($urandom_range(0, 3));
        id_rd        = 5'($urandom_range(0, 3));
        id_rs1_used  = 1'($urandom);
        id_rs2_used  = 1'($urandom);
        id_alu_op    = 4'($urandom);
        id_src1_pc   = ($urandom_range(0, 3) == 0);
        id_src2_imm  = ($urandom_range(0, 3) == 0);
        id_reg_write = 1'($urandom);
        id_mem_read  = ($urandom_range(0, 2) == 0);
        id_mem_write = ($urandom_range(0, 3) == 0);
        id_is_branch = ($urandom_range(0, 3) == 0);
        stall_in     = ($urandom_range(0, 5) == 0);
        flush        = ($urandom_range(0, 9) == 0);
        exm_reg_write = 1'($urandom);
        exm_rd       = 5'($urandom_range(0, 3));
        exm_result   = $urandom;
        mwb_reg_write = 1'($urandom);
        mwb_rd       = 5'($urandom_range(0, 3));
        mwb_wdata    = $urandom;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        m = '0;
        @(negedge clk);

        // Reset state
        step();
        check_eq("reset_ex_valid", {31'd0, ex_valid}, 32'd0);
        check_eq("reset_alu_op", {28'd0, alu_op_out}, 32'd0);
        reset = 1'b1;

        // Pass-through add x3 = x1 + x2
        id_valid = 1'b1; id_alu_op = ALU_ADD; id_rs1 = 5'd1; id_rs2 = 5'd2; id_rd = 5'd3;
        id_rs1_used = 1'b1; id_rs2_used = 1'b1; id_rs1_data = 32'd5; id_rs2_data = 32'd7;
        id_reg_write = 1'b1;
        step();
        id_valid = 1'b0;
        #1;
        check_eq("pass_in_1", alu_in_1, 32'd5);
        check_eq("pass_in_2", alu_in_2, 32'd7);
        check_eq("pass_valid", {31'd0, ex_valid}, 32'd1);
        step();

        // Forward priority on ex_rs1 = 3
        id_valid = 1'b1; id_rs1 = 5'd3; id_rs1_data = 32'h99; id_rs2 = 5'd0;
        step();
        id_valid = 1'b0; stall_in = 1'b1;
        exm_reg_write = 1'b1; exm_rd = 5'd3; exm_result = 32'h11;
        mwb_reg_write = 1'b1; mwb_rd = 5'd3; mwb_wdata = 32'h22;
        #1 check_eq("fwd_exm_wins", alu_in_1, 32'h11);
        exm_reg_write = 1'b0;
        #1 check_eq("fwd_mwb", alu_in_1, 32'h22);
        exm_reg_write = 1'b1; exm_rd = 5'd0; mwb_rd = 5'd0;
        #1 check_eq("fwd_x0_none", alu_in_1, 32'h99);
        step();
        idle_inputs();

        // Load-use: lw x4 in EX, add reading x4 in ID
        id_valid = 1'b1; id_mem_read = 1'b1; id_reg_write = 1'b1; id_rd = 5'd4;
        step();
        id_mem_read = 1'b0; id_rs1 = 5'd1; id_rs2 = 5'd4; id_rs2_used = 1'b1; id_rd = 5'd5;
        #1 check_eq("lu_stall", {31'd0, load_use_stall}, 32'd1);
        step();
        #1 check_eq("lu_bubble", {31'd0, ex_valid}, 32'd0);
        step();
        #1 check_eq("lu_add_enters", {31'd0, ex_valid}, 32'd1);
        check_eq("lu_add_rd", {27'd0, ex_rd}, 32'd5);
        idle_inputs();

        // Stall capture of a MEM/WB forward that then retires
        id_valid = 1'b1; id_rs1 = 5'd5; id_rs1_data = 32'h0;
        step();
        idle_inputs();
        stall_in = 1'b1; mwb_reg_write = 1'b1; mwb_rd = 5'd5; mwb_wdata = 32'hAB;
        repeat (3) step();
        mwb_reg_write = 1'b0;
        #1 check_eq("stall_hold_fwd", alu_in_1, 32'hAB);
        step();
        idle_inputs();

        // Flush together with stall kills a store
        id_valid = 1'b1; id_mem_write = 1'b1;
        step();
        idle_inputs();
        flush = 1'b1; stall_in = 1'b1;
        step();
        #1 check_eq("flush_valid", {31'd0, ex_valid}, 32'd0);
        check_eq("flush_mem_write", {31'd0, ex_mem_write}, 32'd0);
        idle_inputs();

        // Branch target wrap
        id_valid = 1'b1; id_is_branch = 1'b1; id_pc = 32'hFFFF_FFFC; id_imm = 32'd8;
        step();
        idle_inputs();
        #1 check_eq("branch_wrap", ex_branch_target, 32'h0000_0004);

        // Reset during stall
        stall_in = 1'b1; reset = 1'b0;
        step();
        idle_inputs();

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            random_inputs();
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
